// File: rtl/alu_exec_unit_pkg.sv
// Shared opcode constants, FSM/shifter enums and decode helpers for the execute-stage ALU.
// Also imported by alu control so both sides agree on the 4-bit alu_code encoding.
package alu_exec_unit_pkg;

    localparam int unsigned ALU_CODE_W = 4;

    localparam logic [ALU_CODE_W-1:0] ALU_SLL = 4'b0000;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL = 4'b0001;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA = 4'b0010;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0011;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0100;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0101;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0110;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR = 4'b0111;
    localparam logic [ALU_CODE_W-1:0] ALU_NOR = 4'b1000;

    typedef enum logic {StIdle, StShift} state_e;

    typedef enum logic [1:0] {ShLeft, ShRightLogic, ShRightArith} shift_mode_e;

    function automatic logic is_shift(input logic [ALU_CODE_W-1:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

    function automatic shift_mode_e shift_mode(input logic [ALU_CODE_W-1:0] code);
        shift_mode_e m;
        case (code)
            ALU_SRL: m = ShRightLogic;
            ALU_SRA: m = ShRightArith;
            default: m = ShLeft;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between operand muxing, the ALU and the EX/MEM register.
// master = producer of requests / consumer of results; slave = the ALU.
interface alu_exec_unit_if
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [ALU_CODE_W-1:0] alu_code;
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     result;
    logic                  zero;
    logic                  bad_code;

    modport master (
        output in_valid, alu_code, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, bad_code
    );

    modport slave (
        input  in_valid, alu_code, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, bad_code
    );

endinterface

// File: rtl/alu_iter_shifter.sv
// Iterative 1-bit-per-cycle shifter; start loads operand and count, done flags the last step.
// result is the next shifted value, so the caller captures it on the same edge as done.
module alu_iter_shifter
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  shift_mode_e        mode,
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] amount,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0]  shreg_q;
    logic [SHAMT_W-1:0] cnt_q;
    shift_mode_e        mode_q;
    logic [DATA_W-1:0]  step;

    always_comb begin
        step = shreg_q;
        unique case (mode_q)
            ShLeft:       step = {shreg_q[DATA_W-2:0], 1'b0};
            ShRightLogic: step = {1'b0, shreg_q[DATA_W-1:1]};
            ShRightArith: step = {shreg_q[DATA_W-1], shreg_q[DATA_W-1:1]};
            default:      step = shreg_q;
        endcase
    end

    assign busy   = (cnt_q != '0);
    assign done   = (cnt_q == SHAMT_W'(1));
    assign result = step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            mode_q  <= ShLeft;
        end else if (start) begin
            shreg_q <= data;
            cnt_q   <= amount;
            mode_q  <= mode;
        end else if (busy) begin
            shreg_q <= step;
            cnt_q   <= cnt_q - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a registered valid/ready result buffer and an IDLE/SHIFT FSM.
// FAST_SHIFT_EN selects a single-cycle barrel shifter instead of alu_iter_shifter.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_unit_if.slave  bus
);

    state_e             state_q;
    logic               out_valid_q;
    logic [DATA_W-1:0]  result_q;
    logic               zero_q;
    logic               bad_code_q;

    logic               accept;
    logic               drain;
    logic               start_shift;
    logic               sh_done;
    logic [DATA_W-1:0]  sh_out;
    logic [DATA_W-1:0]  alu_out;
    logic               alu_bad;
    logic [SHAMT_W-1:0] shamt;

    assign shamt  = bus.op_a[SHAMT_W-1:0];
    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = out_valid_q & bus.out_ready;

`ifdef FAST_SHIFT_EN
    assign bus.in_ready = ~out_valid_q | bus.out_ready;
    assign start_shift  = 1'b0;
    assign sh_done      = 1'b0;
    assign sh_out       = '0;
`else
    logic sh_busy;

    assign bus.in_ready = (state_q == StIdle) & (~out_valid_q | bus.out_ready);
    assign start_shift  = accept & is_shift(bus.alu_code) & (shamt != '0);

    alu_iter_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .start  (start_shift),
        .mode   (shift_mode(bus.alu_code)),
        .data   (bus.op_b),
        .amount (shamt),
        .busy   (sh_busy),
        .done   (sh_done),
        .result (sh_out)
    );

    shifter_tracks_fsm: assert property (@(posedge clk) disable iff (reset)
        sh_busy == (state_q == StShift));
`endif

    always_comb begin
        alu_out = '0;
        alu_bad = 1'b0;
        case (bus.alu_code)
`ifdef FAST_SHIFT_EN
            ALU_SLL: alu_out = bus.op_b << shamt;
            ALU_SRL: alu_out = bus.op_b >> shamt;
            ALU_SRA: alu_out = $signed(bus.op_b) >>> shamt;
`else
            // Only reached with n==0; n>0 goes through the iterative shifter.
            ALU_SLL, ALU_SRL, ALU_SRA: alu_out = bus.op_b;
`endif
            ALU_ADD: alu_out = bus.op_a + bus.op_b;
            ALU_SUB: alu_out = bus.op_a - bus.op_b;
            ALU_AND: alu_out = bus.op_a & bus.op_b;
            ALU_OR:  alu_out = bus.op_a | bus.op_b;
            ALU_XOR: alu_out = bus.op_a ^ bus.op_b;
            ALU_NOR: alu_out = ~(bus.op_a | bus.op_b);
            default: alu_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            bad_code_q  <= 1'b0;
        end else begin
            if (drain) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (start_shift) begin
                            state_q <= StShift;
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= alu_out;
                            zero_q      <= (alu_out == '0);
                            bad_code_q  <= alu_bad;
                        end
                    end
                end
                StShift: begin
                    // Output buffer is guaranteed empty here: accept required it free.
                    if (sh_done) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b1;
                        result_q    <= sh_out;
                        zero_q      <= (sh_out == '0);
                        bad_code_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.bad_code  = bad_code_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: reset, back-to-back ops, shifts,
// backpressure, boundary cases and illegal codes, with hand-computed expectations.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int unsigned DATA_W = 32;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    alu_exec_unit_if #(.DATA_W(DATA_W)) bus ();

    alu_exec_unit #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [3:0] code,
                           input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.alu_code = code;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    // One-shot request: present for one cycle, then withdraw.
    task automatic send(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        set_req(1'b1, code, a, b);
        step();
        set_req(1'b0, ALU_ADD, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;

        set_req(1'b0, ALU_ADD, 32'h0, 32'h0);
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_result",    bus.result,         32'h0);
        check_eq("rst_zero",      32'(bus.zero),      32'd1);
        check_eq("rst_bad_code",  32'(bus.bad_code),  32'd0);
        reset = 1'b0;
        step();
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Back-to-back with out_ready=1
        set_req(1'b1, ALU_ADD, 32'd5, 32'd7);
        step();
        check_eq("b2b_add",       bus.result,         32'd12);
        check_eq("b2b_add_valid", 32'(bus.out_valid), 32'd1);
        set_req(1'b1, ALU_SUB, 32'd3, 32'd5);
        check_eq("b2b_in_ready",  32'(bus.in_ready),  32'd1);
        step();
        check_eq("b2b_sub",       bus.result,         32'hFFFF_FFFE);
        check_eq("b2b_sub_valid", 32'(bus.out_valid), 32'd1);
        set_req(1'b1, ALU_NOR, 32'h0, 32'h0);
        step();
        check_eq("b2b_nor",       bus.result,         32'hFFFF_FFFF);
        check_eq("b2b_nor_zero",  32'(bus.zero),      32'd0);
        set_req(1'b0, ALU_ADD, 32'h0, 32'h0);
        step();
        check_eq("b2b_drained",   32'(bus.out_valid), 32'd0);

        // sra 0x80000000 by 4
        send(ALU_SRA, 32'd4, 32'h8000_0000);
`ifndef FAST_SHIFT_EN
        for (int k = 1; k <= 4; k++) begin
            check_eq("sra_in_ready_busy", 32'(bus.in_ready),  32'd0);
            check_eq("sra_not_yet_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
`endif
        check_eq("sra_valid",  32'(bus.out_valid), 32'd1);
        check_eq("sra_result", bus.result,         32'hF800_0000);
        step();
        check_eq("sra_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure
        bus.out_ready = 1'b0;
        send(ALU_ADD, 32'd1, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check_eq("bp_result",   bus.result,         32'd2);
            check_eq("bp_valid",    32'(bus.out_valid), 32'd1);
            check_eq("bp_in_ready", 32'(bus.in_ready),  32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check_eq("bp_drained", 32'(bus.out_valid), 32'd0);

        // Boundaries
        send(ALU_SLL, 32'd0, 32'h0000_1234);
        check_eq("sll0_valid",  32'(bus.out_valid), 32'd1);
        check_eq("sll0_result", bus.result,         32'h0000_1234);
        step();

        send(ALU_SRL, 32'd31, 32'hFFFF_FFFF);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
`ifdef FAST_SHIFT_EN
        check_eq("srl31_latency", 32'(lat), 32'd1);
`else
        check_eq("srl31_latency", 32'(lat), 32'd32);
`endif
        check_eq("srl31_result", bus.result, 32'h0000_0001);
        step();

        send(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        check_eq("add_wrap_result", bus.result,    32'h0);
        check_eq("add_wrap_zero",   32'(bus.zero), 32'd1);
        step();

        // A few logic ops so the bad-code result has a nonzero predecessor
        send(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        check_eq("and_result", bus.result, 32'h0000_F000);
        step();
        send(ALU_OR, 32'h0000_F0F0, 32'h0000_FF00);
        check_eq("or_result", bus.result, 32'h0000_FFF0);
        step();
        send(ALU_XOR, 32'h0000_00A5, 32'h0000_000F);
        check_eq("xor_result", bus.result, 32'h0000_00AA);
        step();

        // Illegal code, then a legal op clears bad_code
        send(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0);
        check_eq("bad_result",   bus.result,        32'h0);
        check_eq("bad_flag",     32'(bus.bad_code), 32'd1);
        check_eq("bad_zero",     32'(bus.zero),     32'd1);
        check_eq("bad_valid",    32'(bus.out_valid), 32'd1);
        step();
        send(ALU_ADD, 32'd2, 32'd3);
        check_eq("legal_after_bad_flag",   32'(bus.bad_code), 32'd0);
        check_eq("legal_after_bad_result", bus.result,        32'd5);
        check_eq("legal_after_bad_zero",   32'(bus.zero),     32'd0);
        step();

        // Reset in the middle of a 20-step shift
        send(ALU_SLL, 32'd20, 32'h0000_0001);
        repeat (5) step();
        reset = 1'b1;
        #1;
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check_eq("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("midrst_valid_low", 32'(bus.out_valid), 32'd0);
        seen = 0;
        repeat (25) begin
            step();
            if (bus.out_valid) seen++;
        end
        check_eq("midrst_no_result", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
